// File: rtl/i2s_tdm_pkg.sv
// Shared types and limits for the I2S/TDM transmit channel.
package i2s_tdm_pkg;

  localparam int OFFSET_W   = 9;
  localparam int MIN_DATA_W = 8;
  localparam int MAX_DATA_W = 32;
  localparam int MIN_SLOTS  = 2;
  localparam int MAX_SLOTS  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_WAIT_WS,
    ST_OFFSET,
    ST_RUN
  } state_e;

endpackage

// File: rtl/i2s_tx_tdm_channel_if.sv
// Valid/ready sample input of the TDM transmit channel.
interface i2s_tx_tdm_channel_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] fifo_data_i;
  logic              fifo_valid_i;
  logic              fifo_ready_o;

  modport master (output fifo_data_i, output fifo_valid_i, input fifo_ready_o);
  modport slave  (input fifo_data_i, input fifo_valid_i, output fifo_ready_o);
endinterface

// File: rtl/i2s_tdm_serializer.sv
// Per-slot word serializer: loads at bit 0, emits num_bits+1 bits MSB- or LSB-first.
module i2s_tdm_serializer #(
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  input  logic [DATA_W-1:0]         load_data,
  input  logic [$clog2(DATA_W)-1:0] num_bits,
  input  logic                      lsb_first,
  output logic                      sd,
  output logic                      first,
  output logic                      last
);
  localparam int BW = $clog2(DATA_W);

  logic [DATA_W-1:0] sr;
  logic [BW-1:0]     bit_cnt;

  assign first = (bit_cnt == '0);
  assign last  = (bit_cnt == num_bits);

  function automatic logic pick(input logic [DATA_W-1:0] w, input logic [BW-1:0] idx,
                                input logic [BW-1:0] nb, input logic lsb);
    return lsb ? w[idx] : w[nb - idx];
  endfunction

  // The first bit comes straight from load_data so it lands on sd in the load cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      sd      <= 1'b0;
    end else if (clr) begin
      sr      <= '0;
      bit_cnt <= '0;
      sd      <= 1'b0;
    end else if (en) begin
      if (first) begin
        sr <= load_data;
        sd <= pick(load_data, '0, num_bits, lsb_first);
      end else begin
        sd <= pick(sr, bit_cnt, num_bits, lsb_first);
      end
      bit_cnt <= last ? '0 : bit_cnt + 1'b1;
    end else begin
      sd <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_tx_tdm_channel.sv
// I2S/TDM transmit channel: FSM, one-word shadow buffer and valid/ready intake.
// Optional per-slot masking is enabled with `define I2S_TX_TDM_SLOT_MASK_EN.
module i2s_tx_tdm_channel
  import i2s_tdm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_SLOTS = 8
) (
  input  logic                         sck_i,
  input  logic                         rst_i,
  input  logic                         ws_i,
  output logic                         sd_o,
  i2s_tx_tdm_channel_if.slave          fifo,
  output logic                         busy_o,
  output logic                         err_o,
  input  logic                         cfg_en_i,
  input  logic [$clog2(DATA_W)-1:0]    cfg_num_bits_i,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_num_slots_i,
  input  logic                         cfg_lsb_first_i,
  input  logic [OFFSET_W-1:0]          cfg_offset_i
`ifdef I2S_TX_TDM_SLOT_MASK_EN
  ,
  input  logic [NUM_SLOTS-1:0]         cfg_slot_mask_i
`endif
);
  localparam int SW = $clog2(NUM_SLOTS);

  state_e              state;
  logic                ws_q;
  logic [DATA_W-1:0]   shadow;
  logic                shadow_full;
  logic [SW-1:0]       slot_cnt;
  logic [OFFSET_W-1:0] off_cnt;
  logic                ser_first, ser_last;

  logic ws_rise, in_run, abort, slot_start, slot_active, consume, underrun, push;
  logic ser_clr, ser_en;
  logic [DATA_W-1:0] ser_data;

  assign ws_rise = ws_i & ~ws_q;
  assign in_run  = (state == ST_RUN);
  assign abort   = in_run & ws_rise;

`ifdef I2S_TX_TDM_SLOT_MASK_EN
  assign slot_active = cfg_slot_mask_i[slot_cnt];
`else
  assign slot_active = 1'b1;
`endif

  assign slot_start = in_run & ~abort & ser_first;
  assign consume    = slot_start & slot_active & shadow_full;
  assign underrun   = slot_start & slot_active & ~shadow_full;

  // Ready also covers the cycle the shadow is drained, so refill never costs a slot.
  assign fifo.fifo_ready_o = cfg_en_i & (state != ST_IDLE) & (~shadow_full | consume);
  assign push              = fifo.fifo_ready_o & fifo.fifo_valid_i;

  assign busy_o   = (state != ST_IDLE);
  assign ser_clr  = ~cfg_en_i | abort;
  assign ser_en   = in_run & ~abort;
  assign ser_data = consume ? shadow : '0;

  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      ws_q        <= 1'b0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      slot_cnt    <= '0;
      off_cnt     <= '0;
      err_o       <= 1'b0;
    end else begin
      ws_q <= ws_i;
      if (!cfg_en_i) begin
        state       <= ST_IDLE;
        shadow      <= '0;
        shadow_full <= 1'b0;
        slot_cnt    <= '0;
        off_cnt     <= '0;
        err_o       <= 1'b0;
      end else begin
        if (push) begin
          shadow      <= fifo.fifo_data_i;
          shadow_full <= 1'b1;
        end else if (consume) begin
          shadow_full <= 1'b0;
        end
        if (underrun || abort) err_o <= 1'b1;

        case (state)
          ST_IDLE:    state <= ST_PRELOAD;
          ST_PRELOAD: if (push) state <= ST_WAIT_WS;
          ST_WAIT_WS: begin
            if (ws_rise) begin
              slot_cnt <= '0;
              off_cnt  <= '0;
              state    <= (cfg_offset_i != '0) ? ST_OFFSET : ST_RUN;
            end
          end
          ST_OFFSET: begin
            if (off_cnt == cfg_offset_i - 1'b1) state <= ST_RUN;
            else off_cnt <= off_cnt + 1'b1;
          end
          ST_RUN: begin
            // A sync inside the frame restarts it exactly like a fresh sync.
            if (abort) begin
              slot_cnt <= '0;
              off_cnt  <= '0;
              state    <= (cfg_offset_i != '0) ? ST_OFFSET : ST_RUN;
            end else if (ser_last) begin
              if (slot_cnt == cfg_num_slots_i) begin
                slot_cnt <= '0;
                state    <= ST_WAIT_WS;
              end else begin
                slot_cnt <= slot_cnt + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  i2s_tdm_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk       (sck_i),
    .rst       (rst_i),
    .clr       (ser_clr),
    .en        (ser_en),
    .load_data (ser_data),
    .num_bits  (cfg_num_bits_i),
    .lsb_first (cfg_lsb_first_i),
    .sd        (sd_o),
    .first     (ser_first),
    .last      (ser_last)
  );

endmodule

// File: tb/tb_i2s_tx_tdm_channel.sv
// Self-checking bench for i2s_tx_tdm_channel: expected serial frames are rebuilt
// from the word list and slot rules, independent of the design's internals.
module tb_i2s_tx_tdm_channel;
  localparam int DW = 32;
  localparam int NS = 4;

  logic       sck = 1'b0;
  logic       rst_i, ws_i, sd_o, busy_o, err_o, cfg_en, cfg_lsb;
  logic [4:0] cfg_nb;
  logic [1:0] cfg_ns;
  logic [8:0] cfg_off;
`ifdef I2S_TX_TDM_SLOT_MASK_EN
  logic [3:0] mask_cfg;
`endif

  i2s_tx_tdm_channel_if #(.DATA_W(DW)) fifo_if ();

  always #5 sck = ~sck;

  i2s_tx_tdm_channel #(.DATA_W(DW), .NUM_SLOTS(NS)) dut (
    .sck_i           (sck),
    .rst_i           (rst_i),
    .ws_i            (ws_i),
    .sd_o            (sd_o),
    .fifo            (fifo_if),
    .busy_o          (busy_o),
    .err_o           (err_o),
    .cfg_en_i        (cfg_en),
    .cfg_num_bits_i  (cfg_nb),
    .cfg_num_slots_i (cfg_ns),
    .cfg_lsb_first_i (cfg_lsb),
    .cfg_offset_i    (cfg_off)
`ifdef I2S_TX_TDM_SLOT_MASK_EN
    ,
    .cfg_slot_mask_i (mask_cfg)
`endif
  );

  bit          sd_hist [0:32767];
  int          edge_n;
  logic [31:0] src_q[$];
  logic [31:0] words_q[$];
  int          n_xfer;
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit clock: drive source, take the edge, record sd_o on the following negedge.
  task automatic cyc();
    logic xfer;
    fifo_if.fifo_valid_i = (src_q.size() > 0);
    fifo_if.fifo_data_i  = (src_q.size() > 0) ? src_q[0] : '0;
    #1;
    xfer = fifo_if.fifo_valid_i && fifo_if.fifo_ready_o;
    @(posedge sck);
    edge_n++;
    if (xfer) begin
      void'(src_q.pop_front());
      n_xfer++;
    end
    @(negedge sck);
    sd_hist[edge_n] = sd_o;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push_word(input logic [31:0] w);
    src_q.push_back(w);
    words_q.push_back(w);
  endtask

  task automatic enable_cfg(input int nb, input int ns, input bit lsb, input int off);
    cfg_nb  = nb[4:0];
    cfg_ns  = ns[1:0];
    cfg_lsb = lsb;
    cfg_off = off[8:0];
    cfg_en  = 1'b1;
    run(4);
  endtask

  task automatic shutdown();
    cfg_en = 1'b0;
    cyc();
    src_q.delete();
    words_q.delete();
    n_xfer = 0;
  endtask

  task automatic start_frame(output int k);
    ws_i = 1'b1;
    cyc();
    k = edge_n;
    ws_i = 1'b0;
  endtask

  // Reference: slot s bit j sits at edge k+1+off+s*(nb+1)+j; active slots take the next
  // listed word if one exists, otherwise they go out as zeros and count as underrun.
  task automatic check_frame(input int k, input int off, input int nb, input int ns, input bit lsb,
                             input logic [3:0] msk, inout int widx, output bit uf);
    logic [31:0] m, expw, obsw;
    logic        acc;
    int          base, e0;
    uf   = 1'b0;
    m    = (nb == 31) ? 32'hFFFF_FFFF : ((32'd1 << (nb + 1)) - 32'd1);
    base = k + 1 + off;
    if (off > 0) begin
      acc = 1'b0;
      for (int e = k + 1; e < base; e++) acc |= sd_hist[e];
      chk("offset_zero", {31'd0, acc}, 32'd0);
    end
    for (int s = 0; s <= ns; s++) begin
      expw = '0;
      if (msk[s]) begin
        if (widx < words_q.size()) begin
          expw = words_q[widx] & m;
          widx++;
        end else begin
          uf = 1'b1;
        end
      end
      obsw = '0;
      for (int j = 0; j <= nb; j++) begin
        if (lsb) obsw[j] = sd_hist[base + s * (nb + 1) + j];
        else     obsw[nb - j] = sd_hist[base + s * (nb + 1) + j];
      end
      chk($sformatf("slot%0d_nb%0d_lsb%0d_off%0d", s, nb, lsb, off), obsw, expw);
    end
    e0  = base + (ns + 1) * (nb + 1);
    acc = 1'b0;
    for (int e = e0; e < e0 + 3; e++) acc |= sd_hist[e];
    chk("tail_zero", {31'd0, acc}, 32'd0);
  endtask

  initial begin
    int  k, k2, widx;
    bit  uf;
    logic acc;
    errors = 0; checks = 0; edge_n = 0; n_xfer = 0;
    rst_i = 1'b1; ws_i = 1'b0; cfg_en = 1'b0; cfg_lsb = 1'b0;
    cfg_nb = 5'd15; cfg_ns = 2'd3; cfg_off = '0;
`ifdef I2S_TX_TDM_SLOT_MASK_EN
    mask_cfg = 4'hF;
`endif
    fifo_if.fifo_valid_i = 1'b0;
    fifo_if.fifo_data_i  = '0;
    @(negedge sck);
    run(2);
    chk("rst_sd", {31'd0, sd_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_ready", {31'd0, fifo_if.fifo_ready_o}, 32'd0);
    rst_i = 1'b0;
    run(2);

    // Directed frame, MSB-first, no offset
    push_word(32'hA5A5); push_word(32'h1234); push_word(32'hFFFF); push_word(32'h0001);
    enable_cfg(15, 3, 1'b0, 0);
    chk("busy_enabled", {31'd0, busy_o}, 32'd1);
    start_frame(k);
    run(68);
    widx = 0;
    check_frame(k, 0, 15, 3, 1'b0, 4'hF, widx, uf);
    chk("err_msb_frame", {31'd0, err_o}, {31'd0, uf});
    shutdown();

    // LSB-first with one-cycle offset
    push_word(32'h0003); push_word($urandom()); push_word($urandom()); push_word($urandom());
    enable_cfg(15, 3, 1'b1, 1);
    start_frame(k);
    run(70);
    chk("off1_k1", {31'd0, sd_hist[k + 1]}, 32'd0);
    chk("off1_k2", {31'd0, sd_hist[k + 2]}, 32'd1);
    chk("off1_k3", {31'd0, sd_hist[k + 3]}, 32'd1);
    chk("off1_k4", {31'd0, sd_hist[k + 4]}, 32'd0);
    widx = 0;
    check_frame(k, 1, 15, 3, 1'b1, 4'hF, widx, uf);
    chk("err_lsb_frame", {31'd0, err_o}, {31'd0, uf});
    shutdown();

    // Randomized configurations, two back-to-back frames each
    for (int it = 0; it < 5; it++) begin
      int nb, ns, off, fl;
      bit lsb;
      nb  = $urandom_range(31, 7);
      ns  = $urandom_range(3, 1);
      off = $urandom_range(4, 0);
      lsb = 1'($urandom_range(1, 0));
      fl  = (ns + 1) * (nb + 1);
      for (int w = 0; w < 2 * (ns + 1); w++) push_word($urandom());
      enable_cfg(nb, ns, lsb, off);
      widx = 0;
      start_frame(k);
      run(off + fl + 4);
      check_frame(k, off, nb, ns, lsb, 4'hF, widx, uf);
      start_frame(k);
      run(off + fl + 4);
      check_frame(k, off, nb, ns, lsb, 4'hF, widx, uf);
      chk("err_random", {31'd0, err_o}, {31'd0, uf});
      shutdown();
    end

    // Underrun: only one word ever offered
    push_word(32'hC3C3);
    enable_cfg(15, 3, 1'b0, 0);
    start_frame(k);
    run(68);
    widx = 0;
    check_frame(k, 0, 15, 3, 1'b0, 4'hF, widx, uf);
    chk("err_underrun", {31'd0, err_o}, {31'd0, uf});
    run(10);
    chk("err_sticky", {31'd0, err_o}, 32'd1);
    shutdown();
    chk("err_cleared", {31'd0, err_o}, 32'd0);
    chk("busy_cleared", {31'd0, busy_o}, 32'd0);

    // Sync inside slot 2 aborts and restarts with the next word
    for (int w = 0; w < 7; w++) push_word($urandom());
    enable_cfg(15, 3, 1'b0, 0);
    start_frame(k);
    run(37);
    start_frame(k2);
    run(68);
    widx = 3;
    check_frame(k2, 0, 15, 3, 1'b0, 4'hF, widx, uf);
    chk("err_abort", {31'd0, err_o}, 32'd1);

    // Asynchronous reset mid-slot
    push_word(32'hFFFF);
    start_frame(k);
    run(10);
    chk("pre_reset_sd", {31'd0, sd_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_sd", {31'd0, sd_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_err", {31'd0, err_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, fifo_if.fifo_ready_o}, 32'd0);
    src_q.delete();
    @(negedge sck);
    run(2);
    rst_i = 1'b0;
    cyc();
    chk("post_rst_busy", {31'd0, busy_o}, 32'd1);
    chk("post_rst_ready", {31'd0, fifo_if.fifo_ready_o}, 32'd1);
    run(10);
    acc = 1'b0;
    for (int e = edge_n - 11; e <= edge_n; e++) acc |= sd_hist[e];
    chk("post_rst_quiet", {31'd0, acc}, 32'd0);
    shutdown();

`ifdef I2S_TX_TDM_SLOT_MASK_EN
    // Masked slots 1 and 3
    mask_cfg = 4'b0101;
    for (int w = 0; w < 6; w++) push_word($urandom());
    enable_cfg(15, 3, 1'b0, 0);
    widx = 0;
    start_frame(k);
    run(68);
    check_frame(k, 0, 15, 3, 1'b0, 4'b0101, widx, uf);
    start_frame(k);
    run(68);
    check_frame(k, 0, 15, 3, 1'b0, 4'b0101, widx, uf);
    chk("err_masked", {31'd0, err_o}, {31'd0, uf});
    chk("xfer_masked", n_xfer, 32'd5);
    shutdown();
    mask_cfg = 4'hF;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
